// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER pair-search flow.
// Mask width, score width, FSM encoding and candidate-index unpacking helpers.
package laser_pkg;

  localparam int NPTS     = 40;
  localparam int CNT_W    = 6;
  localparam int NCAND    = 256;
  localparam int PIPE_LAT = 2;

  typedef logic [NPTS-1:0]  mask_t;
  typedef logic [CNT_W-1:0] score_t;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } coord_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SWEEP  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  function automatic logic [3:0] idx_x(input logic [7:0] idx);
    return idx[3:0];
  endfunction

  function automatic logic [3:0] idx_y(input logic [7:0] idx);
    return idx[7:4];
  endfunction

endpackage

// File: rtl/laser_pair_search_if.sv
// Mask read port, control and result bundle of the pair search.
// master = search engine side, slave = mask store / controller side.
interface laser_pair_search_if;
  import laser_pkg::*;

  logic            START;
  logic [7:0]      MASK_RADDR;
  logic [NPTS-1:0] MASK_RDATA;
  logic [3:0]      C1X;
  logic [3:0]      C1Y;
  logic [3:0]      C2X;
  logic [3:0]      C2Y;
  logic [5:0]      SCORE;
  logic            BUSY;
  logic            DONE;

  modport master (
    input  START, MASK_RDATA,
    output MASK_RADDR, C1X, C1Y, C2X, C2Y, SCORE, BUSY, DONE
  );

  modport slave (
    output START, MASK_RDATA,
    input  MASK_RADDR, C1X, C1Y, C2X, C2Y, SCORE, BUSY, DONE
  );

endinterface

// File: rtl/laser_popcount.sv
// Combinational population count of one NPTS-bit cover mask.
// Zero latency; no flow control.
module laser_popcount
  import laser_pkg::*;
(
  input  logic [NPTS-1:0]  bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NPTS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/laser_pair_search.sv
// Alternating coordinate-ascent search for two circle centres over 256 cover masks.
// Each sweep is 256 reads plus a 2-cycle drain, then a 1-cycle commit; START is ignored while busy.
module laser_pair_search
  import laser_pkg::*;
#(
  parameter int MAX_SWEEPS = 8
)
(
  input logic                 CLK,
  input logic                 RST,
  laser_pair_search_if.master bus
);

  localparam int SW_W = $clog2(MAX_SWEEPS + 1);
  localparam int SWEEP_LAST = NCAND + PIPE_LAT - 1;

  logic [1:0]      state;
  logic [8:0]      cnt;
  logic            mov_c2;
  logic [SW_W-1:0] sweeps;

  mask_t  fixed_mask;
  score_t cur_score;
  score_t best_score;
  mask_t  best_mask;
  logic [7:0] best_idx;

  score_t     pop;
  score_t     score_q;
  mask_t      mask_q;
  logic [7:0] score_idx;
  logic       score_vld;

  coord_t c1;
  coord_t c2;
  score_t score_out;

  laser_popcount u_pop (
    .bits  (fixed_mask | bus.MASK_RDATA),
    .count (pop)
  );

  // Read data in sweep cycle n belongs to address n-1; only cycles 1..256 carry a candidate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      score_vld <= 1'b0;
      score_q   <= '0;
      mask_q    <= '0;
      score_idx <= '0;
    end else begin
      score_vld <= (state == SWEEP) && (cnt >= 9'd1) && (cnt <= 9'd256);
      score_q   <= pop;
      mask_q    <= bus.MASK_RDATA;
      score_idx <= cnt[7:0] - 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      mov_c2     <= 1'b0;
      sweeps     <= '0;
      fixed_mask <= '0;
      cur_score  <= '0;
      best_score <= '0;
      best_mask  <= '0;
      best_idx   <= '0;
      c1         <= '0;
      c2         <= '0;
      score_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            state      <= SWEEP;
            cnt        <= '0;
            mov_c2     <= 1'b0;
            sweeps     <= '0;
            fixed_mask <= '0;
            cur_score  <= '0;
            best_score <= '0;
            best_mask  <= '0;
            best_idx   <= '0;
            c1         <= '0;
            c2         <= '0;
            score_out  <= '0;
          end
        end

        SWEEP: begin
          // Strict compare keeps the lowest index on ties.
          if (score_vld && (score_q > best_score)) begin
            best_score <= score_q;
            best_mask  <= mask_q;
            best_idx   <= score_idx;
          end
          if (cnt == 9'(SWEEP_LAST)) begin
            state <= COMMIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        COMMIT: begin
          if (best_score > cur_score) begin
            if (mov_c2) begin
              c2.x <= idx_x(best_idx);
              c2.y <= idx_y(best_idx);
            end else begin
              c1.x <= idx_x(best_idx);
              c1.y <= idx_y(best_idx);
            end
            cur_score  <= best_score;
            fixed_mask <= best_mask;
            mov_c2     <= ~mov_c2;
            sweeps     <= sweeps + SW_W'(1);
            if (sweeps == SW_W'(MAX_SWEEPS - 1)) begin
              state     <= FINISH;
              score_out <= best_score;
            end else begin
              state      <= SWEEP;
              best_score <= '0;
              best_mask  <= '0;
              best_idx   <= '0;
            end
          end else begin
            state     <= FINISH;
            score_out <= cur_score;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Address holds at 255 through the two drain cycles.
  assign bus.MASK_RADDR = cnt[8] ? 8'hFF : cnt[7:0];
  assign bus.C1X        = c1.x;
  assign bus.C1Y        = c1.y;
  assign bus.C2X        = c2.x;
  assign bus.C2Y        = c2.y;
  assign bus.SCORE      = score_out;
  assign bus.BUSY       = (state == SWEEP) || (state == COMMIT);
  assign bus.DONE       = (state == FINISH);

endmodule

// File: tb/tb_laser_pair_search.sv
// Directed and randomized checks of laser_pair_search against a loop-based search model.
module tb_laser_pair_search;
  import laser_pkg::*;

  localparam int MAXS      = 8;
  localparam int SWEEP_CYC = 259;
  localparam int LIMIT     = MAXS * SWEEP_CYC + 20;

  logic CLK = 1'b0;
  logic RST;

  laser_pair_search_if bus();

  laser_pair_search #(.MAX_SWEEPS(MAXS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [NPTS-1:0] mem [NCAND];
  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  // Synchronous-read mask store.
  always @(posedge CLK) bus.MASK_RDATA <= mem[bus.MASK_RADDR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NPTS-1:0] rnd40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NPTS-1:0];
  endfunction

  // Reference: best-covering candidate per sweep, alternating circles, stop on no strict gain.
  task automatic model(output logic [3:0] c1x, output logic [3:0] c1y,
                       output logic [3:0] c2x, output logic [3:0] c2y,
                       output int sc, output int nsw);
    logic [NPTS-1:0] fixed;
    logic [7:0] bi;
    int cur, best, bidx;
    bit mov2;
    fixed = '0; cur = 0; mov2 = 0; nsw = 0;
    c1x = 0; c1y = 0; c2x = 0; c2y = 0;
    for (int s = 0; s < MAXS; s++) begin
      best = 0; bidx = 0;
      for (int i = 0; i < NCAND; i++) begin
        if ($countones(fixed | mem[i]) > best) begin
          best = $countones(fixed | mem[i]);
          bidx = i;
        end
      end
      nsw++;
      if (best <= cur) break;
      bi = 8'(bidx);
      if (mov2) begin c2x = bi % 16; c2y = bi / 16; end
      else      begin c1x = bi % 16; c1y = bi / 16; end
      cur = best;
      fixed = mem[bidx];
      mov2 = !mov2;
    end
    sc = cur;
  endtask

  // One START-to-DONE run; extra_at >= 0 re-pulses START at that cycle of the run.
  task automatic run_search(input string tag, input int extra_at);
    logic [3:0] e1x, e1y, e2x, e2y;
    int esc, ensw, t, t_done, bad, pos, expa, extra_done;
    model(e1x, e1y, e2x, e2y, esc, ensw);
    @(negedge CLK); bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    t = 0; t_done = -1; bad = 0;
    while (t < LIMIT) begin
      if (bus.DONE === 1'b1) begin
        t_done = t;
        break;
      end
      if (bus.BUSY !== 1'b1) bad++;
      pos = t % SWEEP_CYC;
      if (pos < SWEEP_CYC - 1) begin
        expa = (pos < NCAND) ? pos : NCAND - 1;
        if (bus.MASK_RADDR !== 8'(expa)) bad++;
      end
      bus.START = (t == extra_at);
      @(negedge CLK);
      t++;
    end
    bus.START = 1'b0;
    // DONE appears in the (sweeps*259 + 2)-th cycle counting the START cycle as the first.
    check({tag, " done_cycle"}, 64'(t_done), 64'(ensw * SWEEP_CYC));
    check({tag, " busy_raddr_seq"}, 64'(bad), 64'd0);
    check({tag, " busy_at_done"}, 64'(bus.BUSY), 64'd0);
    check({tag, " c1"}, {bus.C1X, bus.C1Y}, {e1x, e1y});
    check({tag, " c2"}, {bus.C2X, bus.C2Y}, {e2x, e2y});
    check({tag, " score"}, 64'(bus.SCORE), 64'(esc));
    extra_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) extra_done++;
    end
    check({tag, " single_done"}, 64'(extra_done), 64'd0);
    check({tag, " hold"}, {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 2'b00, bus.SCORE},
          {e1x, e1y, e2x, e2y, 2'b00, 6'(esc)});
  endtask

  initial begin
    logic [NPTS-1:0] lo, hi, m;
    int dones;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.MASK_RDATA = '0;
    for (int i = 0; i < NCAND; i++) mem[i] = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          {bus.MASK_RADDR, bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, bus.SCORE, bus.BUSY, bus.DONE},
          64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // All-zero masks: no gain in the first sweep.
    run_search("zero", -1);
    check("zero const", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 2'b00, bus.SCORE}, 64'd0);

    // Single cluster at (5,7); every other mask is a strict subset.
    for (int i = 0; i < NCAND; i++) mem[i] = rnd40() & ~(40'd1 << $urandom_range(NPTS - 1));
    mem[8'h75] = '1;
    run_search("cluster1", -1);
    check("cluster1 const", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 2'b00, bus.SCORE},
          {4'd5, 4'd7, 4'd0, 4'd0, 8'd40});

    // Two disjoint clusters at (3,3) and (12,12).
    lo = 40'h00000FFFFF;
    hi = 40'hFFFFF00000;
    for (int i = 0; i < NCAND; i++) begin
      if (i % 2 == 0) mem[i] = rnd40() & lo & ~(40'd1 << $urandom_range(19));
      else            mem[i] = rnd40() & hi & ~(40'd1 << $urandom_range(39, 20));
    end
    mem[8'h33] = lo;
    mem[8'hCC] = hi;
    run_search("cluster2", -1);
    check("cluster2 const", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 2'b00, bus.SCORE},
          {4'd3, 4'd3, 4'd12, 4'd12, 8'd40});

    // Tie between identical masks: lowest index wins.
    for (int i = 0; i < NCAND; i++) mem[i] = '0;
    mem[8'h22] = 40'h0000_0003FF;
    mem[8'h90] = 40'h0000_0003FF;
    run_search("tie", -1);
    check("tie const", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 2'b00, bus.SCORE},
          {4'd2, 4'd2, 4'd0, 4'd0, 8'd10});

    // Randomized sparse masks, including a START re-pulse mid-sweep.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCAND; i++) mem[i] = rnd40() & rnd40() & rnd40();
      run_search($sformatf("rand%0d", r), (r == 1) ? 50 : -1);
    end

    // Reset 100 cycles into a sweep aborts with all outputs zero and no DONE.
    for (int i = 0; i < NCAND; i++) mem[i] = rnd40() & rnd40();
    @(negedge CLK); bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    repeat (100) @(negedge CLK);
    m = '0;
    RST = 1'b1;
    #1;
    check("midreset_outputs",
          {bus.MASK_RADDR, bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, bus.SCORE, bus.BUSY, bus.DONE},
          64'(m));
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) dones++;
    end
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    run_search("after_reset", -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
